seq_shift_add_multiplier: RTL and testbench



---
 rtl/seq_shift_add_multiplier.sv | 129 ++++++++++++
 tb/tb_seq_shift_add_multiplier.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/seq_shift_add_multiplier.sv
// Iterative shift-and-add multiplier with signed/unsigned operands and valid/ready handshakes.
// Optional early termination on an exhausted multiplier: define SEQ_MULT_EARLY_TERM_EN.
module seq_shift_add_multiplier #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_CYCLE = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int unsigned N     = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CNT_W = $clog2(N + 1);
  localparam int unsigned PW    = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [PW-1:0]    product_q, product_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_q, neg_d;

  logic [PW-1:0]    partial;
  logic [PW-1:0]    acc_sum;
  logic [WIDTH-1:0] mplier_shift;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             last_step;

  // Signed operands are reduced to magnitudes; the sign is reapplied to the final sum.
  always_comb begin
    mag_a = multiplicand;
    mag_b = multiplier;
    if (is_signed && multiplicand[WIDTH-1]) mag_a = ~multiplicand + WIDTH'(1);
    if (is_signed && multiplier[WIDTH-1])   mag_b = ~multiplier + WIDTH'(1);
  end

  always_comb begin
    partial = '0;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      if (mplier_q[i]) partial = partial + (mcand_q << i);
    end
  end

  assign acc_sum      = acc_q + partial;
  assign mplier_shift = mplier_q >> BITS_PER_CYCLE;

`ifdef SEQ_MULT_EARLY_TERM_EN
  assign last_step = (cnt_q == CNT_W'(N - 1)) || (mplier_shift == '0);
`else
  assign last_step = (cnt_q == CNT_W'(N - 1));
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    product_d = product_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          acc_d    = '0;
          cnt_d    = '0;
          mcand_d  = PW'(mag_a);
          mplier_d = mag_b;
          neg_d    = is_signed & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
          state_d  = CALC;
        end
      end
      CALC: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << BITS_PER_CYCLE;
        mplier_d = mplier_shift;
        cnt_d    = cnt_q + CNT_W'(1);
        if (last_step) begin
          product_d = neg_q ? (~acc_sum + PW'(1)) : acc_sum;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign product   = product_q;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Self-checking bench: directed vector table, handshake/reset corner sequences, random vs model.
module tb_seq_shift_add_multiplier;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned BPC   = 2;
  localparam int unsigned NFULL = WIDTH / BPC;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  multiplicand;
  logic [WIDTH-1:0]  multiplier;
  logic              is_signed;
  logic              out_valid;
  logic              out_ready;
  logic [2*WIDTH-1:0] product;
  logic              busy;

  int n_cmp  = 0;
  int n_fail = 0;

  seq_shift_add_multiplier #(.WIDTH(WIDTH), .BITS_PER_CYCLE(BPC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .multiplicand(multiplicand), .multiplier(multiplier), .is_signed(is_signed),
    .out_valid(out_valid), .out_ready(out_ready), .product(product), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               s;
    logic [2*WIDTH-1:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] model_prod(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  function automatic int model_lat(input logic [31:0] b, input logic s);
`ifdef SEQ_MULT_EARLY_TERM_EN
    logic [31:0] mag;
    int h;
    mag = (s && b[31]) ? (~b + 32'd1) : b;
    h = -1;
    for (int i = 0; i < 32; i++) if (mag[i]) h = i;
    if (h < 0) return 1;
    return (h + BPC) / BPC;
`else
    return NFULL;
`endif
  endfunction

  // One full transaction. hold: cycles of out_ready=0 after out_valid; poke: pulse in_valid mid-CALC.
  task automatic run_txn(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [63:0] exp, input int hold, input bit poke);
    int lat, bad_rdy, wait_cnt, unstable;
    logic [63:0] held;
    @(negedge clk);
    wait_cnt = 0;
    while (!in_ready && wait_cnt < 100) begin @(negedge clk); wait_cnt++; end
    check({name, "_in_ready_idle"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; multiplicand = a; multiplier = b; is_signed = s;
    @(posedge clk); #1;
    in_valid = 1'b0; multiplicand = $urandom; multiplier = $urandom; is_signed = 1'($urandom);
    lat = 0; bad_rdy = 0;
    while (!out_valid && lat < 100) begin
      if (in_ready || !busy) bad_rdy++;
      if (poke && lat == 2) begin
        in_valid = 1'b1; multiplicand = 32'h1234_5678; multiplier = 32'h0000_0777; is_signed = 1'b0;
      end
      if (poke && lat == 3) in_valid = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    check({name, "_latency"}, 64'(lat), 64'(model_lat(b, s)));
    check({name, "_in_ready_low"}, 64'(bad_rdy), 64'd0);
    check({name, "_product"}, product, exp);
    held = product; unstable = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (product !== held || in_ready || !out_valid) unstable++;
    end
    if (hold > 0) check({name, "_backpressure"}, 64'(unstable), 64'd0);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, "_release"}, {62'd0, out_valid, in_ready}, 64'd1);
  endtask

  vec_t vecs[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001});
    vecs.push_back('{32'hFFFF_FFF9, 32'h0000_0003, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB});
    vecs.push_back('{32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000});
    vecs.push_back('{32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 64'hC000_0000_8000_0000});
    vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001});
    vecs.push_back('{32'h8000_0000, 32'h0000_0002, 1'b0, 64'h0000_0001_0000_0000});
    vecs.push_back('{32'h1234_5678, 32'h0000_0000, 1'b0, 64'h0});
    vecs.push_back('{32'h0000_0009, 32'h0000_0003, 1'b0, 64'd27});
    vecs.push_back('{32'h0000_0001, 32'h8000_0000, 1'b0, 64'h0000_0000_8000_0000});

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    multiplicand = '0; multiplier = '0; is_signed = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {in_ready, out_valid, busy}, 64'b100);
    check("reset_product", product, 64'd0);
    @(negedge clk); rst = 1'b0;

    foreach (vecs[i]) run_txn($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].exp, 0, 1'b0);

    // Backpressure then a second transaction.
    run_txn("bp", 32'hFFFF_FFF9, 32'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, 10, 1'b0);
    run_txn("bp_next", 32'd5, 32'd6, 1'b0, 64'd30, 0, 1'b0);

    // Asynchronous reset five cycles into CALC.
    @(negedge clk);
    in_valid = 1'b1; multiplicand = 32'hDEAD_BEEF; multiplier = 32'hFFFF_FFFF; is_signed = 1'b0;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("midrst_ctrl", {in_ready, out_valid, busy}, 64'b100);
    check("midrst_product", product, 64'd0);
    @(negedge clk); rst = 1'b0;
    run_txn("after_rst", 32'd12, 32'd11, 1'b0, 64'd132, 0, 1'b0);

    // in_valid during CALC must be ignored.
    run_txn("poke", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 0, 1'b1);

    // out_ready while idle has no effect.
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    check("idle_out_ready", {in_ready, out_valid, busy}, 64'b100);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] ra, rb;
      logic rs;
      ra = $urandom; rb = $urandom; rs = 1'($urandom);
      if (i % 4 == 1) rb = rb >> $urandom_range(31, 0);
      run_txn($sformatf("rnd%0d", i), ra, rb, rs, model_prod(ra, rb, rs), i % 5 == 0 ? 3 : 0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
